sse_feeder: RTL and testbench
=============================

SSE_FEEDER -- requirements
Module: sse_feeder

Interface
REQ-001 Parameter DEPTH, default 8: pair-FIFO depth in (A,B) entries; power of two, 2..256.
REQ-002 Parameter TIMEOUT, default 255: maximum cycles waited for sse_ready after stop is asserted.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 wr_en  input  1  host push strobe for one (A,B) pair.
REQ-006 wr_a  input  32  host operand A, IEEE-754 single.
REQ-007 wr_b  input  32  host operand B, IEEE-754 single.
REQ-008 wr_full  output  1  FIFO holds DEPTH entries.
REQ-009 go  input  1  host request to start one SSE run.
REQ-010 busy  output  1  run in progress (state != IDLE).
REQ-011 sse_a  output  32  A operand to the SSE unit.
REQ-012 sse_b  output  32  B operand to the SSE unit.
REQ-013 sse_rst  output  1  clear pulse to the SSE accumulator.
REQ-014 sse_stop  output  1  end-of-stream to the SSE unit.
REQ-015 sse_next  input  1  SSE has consumed the presented pair.
REQ-016 sse_ready  input  1  SSE result sse_y is valid.
REQ-017 sse_y  input  32  SSE result, IEEE-754 single.
REQ-018 result  output  32  captured sse_y.
REQ-019 result_valid  output  1  result holds the output of the last completed run.
REQ-020 timeout  output  1  sticky flag: the last run ended without sse_ready.

Function
REQ-021 States are IDLE, CLEAR, FEED and WAIT; all state is clocked on the clk rising edge.
REQ-022 FIFO writes:
- wr_en with wr_full=0 stores {wr_a,wr_b} in any state.
- wr_en with wr_full=1 is dropped, including a cycle with a simultaneous pop.
REQ-023 go acceptance:
- go is accepted only in IDLE with FIFO count>0.
- On acceptance, the block latches N=count, clears result_valid and timeout, and enters CLEAR.
- go in any other state, or with an empty FIFO, is ignored.
REQ-024 Run length: only the N latched pairs are fed in a run; pairs written after go remain queued for the next run.
REQ-025 CLEAR (exactly 1 cycle):
- sse_rst=1.
- Head pair is popped onto sse_a/sse_b; remaining=N-1.
- sse_next is ignored.
- Next state is FEED.
REQ-026 FEED:
- sse_rst=0; sse_a/sse_b hold the presented pair until sse_next=1.
- On sse_next with remaining>0: the next pair is popped and appears on sse_a/sse_b the following cycle; remaining decrements.
- On sse_next with remaining=0: next state is WAIT.
REQ-027 WAIT:
- sse_stop=1 throughout; a timeout counter starts at 0 on entry and increments each cycle.
- When sse_ready=1: result<=sse_y, result_valid<=1, and the next state is IDLE with sse_stop=0.
- When the counter reaches TIMEOUT without sse_ready: timeout<=1, result unchanged, next state IDLE.
REQ-028 sse_ready and sse_next outside their owning state (WAIT and FEED respectively) are ignored.
REQ-029 Latency from go to the first sse_rst is 1 cycle; from sse_ready to result_valid it is 1 cycle.
REQ-030 wr_full and busy are registered or derived from registered state only, with no combinational path from inputs.

Reset
REQ-031 When rst=1, asynchronously:
- state=IDLE; FIFO emptied.
- sse_a=sse_b=result=32'h0.
- sse_rst=sse_stop=result_valid=timeout=busy=wr_full=0.
REQ-032 Reset mid-run discards all queued pairs and any partial run; no result is captured.

Verification
REQ-033 Three-pair run:
- Stimulus: push (0x40800000,0x40000000), (0x41000000,0x40800000), (0x41800000,0x41000000); go; SSE model asserts next one cycle after each pair.
- Required: pairs appear in push order; sse_rst high exactly 1 cycle; sse_stop rises after the third next; model returns 0x42A80000 and result=0x42A80000 with result_valid=1.
REQ-034 Full FIFO: push 9 pairs with DEPTH=8 -> wr_full=1 after the 8th push, the 9th is dropped, and the run feeds exactly 8 pairs.
REQ-035 Empty or busy go:
- go with an empty FIFO -> busy stays 0 and there is no sse_rst.
- go during FEED -> ignored, with no second sse_rst.
REQ-036 Timeout: sse_ready held 0 in WAIT -> after 255 cycles timeout=1, busy=0, result_valid=0, sse_stop=0.
REQ-037 Mid-run reset: assert rst during FEED after 1 of 3 pairs -> all outputs go to 0 immediately and the FIFO is empty; a subsequent go is ignored.
REQ-038 Late push: push 2 pairs, go, push 1 more during FEED -> the run feeds 2 pairs; a second go feeds the remaining pair.

Source files
------------

// File: rtl/sse_feeder.sv
// Feeds queued (A,B) operand pairs to an SSE accumulator unit, one run per go,
// and captures the unit's result or flags a timeout when it never answers.
module sse_feeder #(
    parameter int DEPTH   = 8,
    parameter int TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        wr_en,
    input  logic [31:0] wr_a,
    input  logic [31:0] wr_b,
    output logic        wr_full,
    input  logic        go,
    output logic        busy,
    output logic [31:0] sse_a,
    output logic [31:0] sse_b,
    output logic        sse_rst,
    output logic        sse_stop,
    input  logic        sse_next,
    input  logic        sse_ready,
    input  logic [31:0] sse_y,
    output logic [31:0] result,
    output logic        result_valid,
    output logic        timeout,
    output logic [1:0]  dbg_state_o
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = AW + 1;
    localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
    localparam logic [TW-1:0] TO_LAST  = TW'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_CLEAR = 2'd1,
        S_FEED  = 2'd2,
        S_WAIT  = 2'd3
    } state_t;

    state_t        state_q, state_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic [CW-1:0] rem_q, rem_d;
    logic [TW-1:0] tcnt_q, tcnt_d;
    logic [31:0]   sse_a_q, sse_a_d;
    logic [31:0]   sse_b_q, sse_b_d;
    logic [31:0]   result_q, result_d;
    logic          valid_q, valid_d;
    logic          timeout_q, timeout_d;
    logic [63:0]   mem_q [DEPTH];
    logic [63:0]   head;
    logic          full;
    logic          push;
    logic          pop;

    // Full is a pure function of the registered count, so a push that
    // coincides with a pop while full is still refused.
    assign full = (count_q == FULL_CNT);
    assign push = wr_en && !full;
    assign head = mem_q[rd_ptr_q];

    always_comb begin
        state_d   = state_q;
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        count_d   = count_q;
        rem_d     = rem_q;
        tcnt_d    = tcnt_q;
        sse_a_d   = sse_a_q;
        sse_b_d   = sse_b_q;
        result_d  = result_q;
        valid_d   = valid_q;
        timeout_d = timeout_q;
        pop       = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (go && (count_q != '0)) begin
                    rem_d     = count_q;
                    valid_d   = 1'b0;
                    timeout_d = 1'b0;
                    state_d   = S_CLEAR;
                end
            end
            S_CLEAR: begin
                pop     = 1'b1;
                rem_d   = rem_q - CW'(1);
                state_d = S_FEED;
            end
            S_FEED: begin
                if (sse_next) begin
                    if (rem_q != '0) begin
                        pop   = 1'b1;
                        rem_d = rem_q - CW'(1);
                    end else begin
                        tcnt_d  = '0;
                        state_d = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                if (sse_ready) begin
                    result_d = sse_y;
                    valid_d  = 1'b1;
                    state_d  = S_IDLE;
                end else if (tcnt_q == TO_LAST) begin
                    timeout_d = 1'b1;
                    state_d   = S_IDLE;
                end else begin
                    tcnt_d = tcnt_q + TW'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (pop) begin
            sse_a_d  = head[63:32];
            sse_b_d  = head[31:0];
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        if (push) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            rem_q     <= '0;
            tcnt_q    <= '0;
            sse_a_q   <= '0;
            sse_b_q   <= '0;
            result_q  <= '0;
            valid_q   <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            rem_q     <= rem_d;
            tcnt_q    <= tcnt_d;
            sse_a_q   <= sse_a_d;
            sse_b_q   <= sse_b_d;
            result_q  <= result_d;
            valid_q   <= valid_d;
            timeout_q <= timeout_d;
        end
    end

    // Storage needs no reset: the pointers and count define what is valid.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= {wr_a, wr_b};
        end
    end

    assign wr_full      = full;
    assign busy         = (state_q != S_IDLE);
    assign sse_rst      = (state_q == S_CLEAR);
    assign sse_stop     = (state_q == S_WAIT);
    assign sse_a        = sse_a_q;
    assign sse_b        = sse_b_q;
    assign result       = result_q;
    assign result_valid = valid_q;
    assign timeout      = timeout_q;
    assign dbg_state_o  = state_q;

endmodule

// File: tb/tb_sse_feeder.sv
// Bench for sse_feeder: a table of runs driven through a simple SSE responder,
// plus hand-written empty-go and mid-run-reset sequences.
module tb_sse_feeder;

    localparam int DEPTH   = 8;
    localparam int TIMEOUT = 255;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        wr_en = 1'b0;
    logic [31:0] wr_a = '0;
    logic [31:0] wr_b = '0;
    logic        wr_full;
    logic        go = 1'b0;
    logic        busy;
    logic [31:0] sse_a;
    logic [31:0] sse_b;
    logic        sse_rst;
    logic        sse_stop;
    logic        sse_next = 1'b0;
    logic        sse_ready = 1'b0;
    logic [31:0] sse_y = '0;
    logic [31:0] result;
    logic        result_valid;
    logic        timeout;
    logic [1:0]  dbg_state;

    sse_feeder #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst(rst),
        .wr_en(wr_en), .wr_a(wr_a), .wr_b(wr_b), .wr_full(wr_full),
        .go(go), .busy(busy),
        .sse_a(sse_a), .sse_b(sse_b), .sse_rst(sse_rst), .sse_stop(sse_stop),
        .sse_next(sse_next), .sse_ready(sse_ready), .sse_y(sse_y),
        .result(result), .result_valid(result_valid), .timeout(timeout),
        .dbg_state_o(dbg_state)
    );

    always #5 clk = ~clk;

    int          n_cmp = 0;
    int          n_fail = 0;
    logic [63:0] exp_q[$];
    int          bench_cnt = 0;
    int          fed_run = 0;
    int          rst_cnt = 0;
    int          wait_cycles = 0;
    int          stop_after = -1;
    bit          stop_seen = 0;
    bit          ready_en = 0;
    logic [31:0] y_val = '0;
    logic [31:0] last_result = '0;
    int          seq = 0;

    typedef struct {
        int          n_push;
        bit          late;
        bit          go_feed;
        bit          rdy;
        logic [31:0] y;
        int          exp_fed;
        bit          exp_full;
        logic        exp_valid;
        logic        exp_to;
    } vec_t;

    vec_t        vecs[6];
    logic [31:0] spec_a[3];
    logic [31:0] spec_b[3];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // SSE responder: consumes each presented pair one cycle after it appears,
    // and answers in WAIT when ready_en is set.
    initial begin
        forever begin
            @(negedge clk);
            if (rst) begin
                sse_next  = 1'b0;
                sse_ready = 1'b0;
            end else begin
                if (busy && !sse_rst && !sse_stop) begin
                    if (!sse_next) begin
                        fed_run++;
                        if (exp_q.size() == 0) begin
                            n_cmp++;
                            n_fail++;
                            $display("FAIL fed_pair: got %h, expected no pair", {sse_a, sse_b});
                        end else begin
                            check("fed_pair", {sse_a, sse_b}, exp_q.pop_front());
                            bench_cnt--;
                        end
                        sse_next = 1'b1;
                    end else begin
                        sse_next = 1'b0;
                    end
                end else begin
                    sse_next = 1'b0;
                end
                if (sse_rst) rst_cnt++;
                if (sse_stop) begin
                    if (!stop_seen) begin
                        stop_seen  = 1'b1;
                        stop_after = fed_run;
                    end
                    wait_cycles++;
                    sse_ready = ready_en;
                    sse_y     = y_val;
                end else begin
                    sse_ready = 1'b0;
                end
            end
        end
    end

    task automatic push(input logic [31:0] a, input logic [31:0] b);
        wr_en = 1'b1;
        wr_a  = a;
        wr_b  = b;
        @(negedge clk);
        wr_en = 1'b0;
        if (bench_cnt < DEPTH) begin
            exp_q.push_back({a, b});
            bench_cnt++;
        end
    endtask

    task automatic pulse_go();
        go = 1'b1;
        @(negedge clk);
        go = 1'b0;
    endtask

    task automatic wait_feed(input int budget);
        int n = 0;
        while (!(busy && !sse_rst && !sse_stop) && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (n >= budget) check("wait_feed_bound", 0, 1);
    endtask

    task automatic wait_idle(input int budget);
        int n = 0;
        while (busy && n < budget) begin
            @(negedge clk);
            n++;
        end
        check("wait_idle_bound", {63'b0, busy}, 0);
    endtask

    task automatic clear_run();
        fed_run     = 0;
        rst_cnt     = 0;
        wait_cycles = 0;
        stop_after  = -1;
        stop_seen   = 1'b0;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_busy"}, {63'b0, busy}, 0);
        check({tag, "_wr_full"}, {63'b0, wr_full}, 0);
        check({tag, "_sse_rst"}, {63'b0, sse_rst}, 0);
        check({tag, "_sse_stop"}, {63'b0, sse_stop}, 0);
        check({tag, "_result_valid"}, {63'b0, result_valid}, 0);
        check({tag, "_timeout"}, {63'b0, timeout}, 0);
        check({tag, "_result"}, {32'b0, result}, 0);
        check({tag, "_sse_ab"}, {sse_a, sse_b}, 0);
        check({tag, "_state"}, {62'b0, dbg_state}, 0);
    endtask

    initial begin
        spec_a = '{32'h4080_0000, 32'h4100_0000, 32'h4180_0000};
        spec_b = '{32'h4000_0000, 32'h4080_0000, 32'h4100_0000};
        //           n  late gof rdy  y              fed full valid to
        vecs[0] = '{3, 0, 0, 1, 32'h42A8_0000, 3, 0, 1'b1, 1'b0};
        vecs[1] = '{9, 0, 0, 1, 32'h3F80_0000, 8, 1, 1'b1, 1'b0};
        vecs[2] = '{2, 1, 0, 1, 32'h4049_0FDB, 2, 0, 1'b1, 1'b0};
        vecs[3] = '{0, 0, 0, 1, 32'h4120_0000, 1, 0, 1'b1, 1'b0};
        vecs[4] = '{1, 0, 0, 0, 32'hDEAD_BEEF, 1, 0, 1'b0, 1'b1};
        vecs[5] = '{3, 0, 1, 1, 32'h4200_0000, 3, 0, 1'b1, 1'b0};

        #2;
        check_all_zero("reset");
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        clear_run();
        pulse_go();
        repeat (3) begin
            check("empty_go_busy", {63'b0, busy}, 0);
            @(negedge clk);
        end
        check("empty_go_rst_cnt", rst_cnt, 0);

        for (int r = 0; r < 6; r++) begin
            for (int i = 0; i < vecs[r].n_push; i++) begin
                if (r == 0) begin
                    push(spec_a[i], spec_b[i]);
                end else begin
                    push(32'h3F80_0000 + 32'(seq), 32'hC000_0000 ^ 32'(seq * 3));
                    seq++;
                end
                if (vecs[r].exp_full && i == DEPTH - 2) check("full_before", {63'b0, wr_full}, 0);
                if (vecs[r].exp_full && i >= DEPTH - 1) check("full_after", {63'b0, wr_full}, 1);
            end
            clear_run();
            ready_en = vecs[r].rdy;
            y_val    = vecs[r].y;
            pulse_go();
            check($sformatf("r%0d_go_sse_rst", r), {63'b0, sse_rst}, 1);
            check($sformatf("r%0d_go_busy", r), {63'b0, busy}, 1);
            @(negedge clk);
            check($sformatf("r%0d_rst_one_cycle", r), {63'b0, sse_rst}, 0);
            if (vecs[r].late || vecs[r].go_feed) begin
                wait_feed(20);
                if (vecs[r].late) begin
                    push(32'h5555_0000 + 32'(seq), 32'h0000_AAAA);
                    seq++;
                end
                if (vecs[r].go_feed) pulse_go();
            end
            wait_idle(2000);
            @(negedge clk);
            check($sformatf("r%0d_fed", r), fed_run, vecs[r].exp_fed);
            check($sformatf("r%0d_rst_cnt", r), rst_cnt, 1);
            check($sformatf("r%0d_stop_after", r), stop_after, vecs[r].exp_fed);
            check($sformatf("r%0d_wait_cycles", r), wait_cycles, vecs[r].rdy ? 1 : TIMEOUT);
            check($sformatf("r%0d_valid", r), {63'b0, result_valid}, {63'b0, vecs[r].exp_valid});
            check($sformatf("r%0d_timeout", r), {63'b0, timeout}, {63'b0, vecs[r].exp_to});
            check($sformatf("r%0d_sse_stop", r), {63'b0, sse_stop}, 0);
            check($sformatf("r%0d_wr_full", r), {63'b0, wr_full}, 0);
            if (vecs[r].rdy) last_result = vecs[r].y;
            check($sformatf("r%0d_result", r), {32'b0, result}, {32'b0, last_result});
        end

        // Reset during FEED once the first of three pairs has been consumed.
        for (int i = 0; i < 3; i++) push(spec_a[i], spec_b[i]);
        clear_run();
        ready_en = 1'b1;
        pulse_go();
        begin
            int n = 0;
            while (fed_run < 1 && n < 20) begin
                @(negedge clk);
                n++;
            end
            check("midrst_reached_feed", fed_run, 1);
        end
        #2 rst = 1'b1;
        #1;
        check_all_zero("midrst");
        @(negedge clk);
        rst = 1'b0;
        exp_q.delete();
        bench_cnt = 0;
        @(negedge clk);
        clear_run();
        pulse_go();
        repeat (4) begin
            check("midrst_go_busy", {63'b0, busy}, 0);
            @(negedge clk);
        end
        check("midrst_go_rst_cnt", rst_cnt, 0);
        check("midrst_fed", fed_run, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
